// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite layer mux: pixel/id widths, colour keys,
// built-in test colours and the resolver FSM state encoding.
package sprite_pkg;

  localparam int PIX_W = 24;
  localparam int ID_W  = 5;

  localparam logic [PIX_W-1:0] TRANSP_KEY  = 24'hFF00FF;
  localparam logic [PIX_W-1:0] BG_COLOR    = 24'h000000;
  localparam logic [PIX_W-1:0] TEST_COLOR0 = 24'hFF0087;
  localparam logic [PIX_W-1:0] TEST_COLOR1 = 24'h87FF00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_prio_enc.sv
// Lowest-set-bit priority encoder. idx is N when no bit is set, which lines
// up with the "background" layer code used by the mux.
module sprite_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N) + 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx = IDX_W'(N);
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_layer_mux.sv
// Per-pixel sprite layer resolver. Accepts a request (hit mask, ids, ROM
// addresses), walks hit layers from highest priority, reads each from the
// sprite ROM and returns the first non-transparent colour, else background.
// Optional feature: define SPRITE_MUX_TESTCOLOR_EN to serve object ids 0 and 1
// from built-in opaque test colours without a ROM access.
//
// Handshakes: a request is taken on a clk50 edge with in_valid && in_ready
// (in_ready only in IDLE); a result is held on out_valid until an edge with
// out_valid && out_ready, after which the block returns to IDLE.
module sprite_layer_mux
  import sprite_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int ADDR_W     = 10,
  parameter int ID_W       = sprite_pkg::ID_W,
  parameter int PIX_W      = sprite_pkg::PIX_W
) (
  input  logic                           clk50,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LAYERS-1:0]          layer_hit,
  input  logic [NUM_LAYERS*ID_W-1:0]     layer_obj_id,
  input  logic [NUM_LAYERS*ADDR_W-1:0]   layer_addr,
  output logic                           rom_en,
  output logic [ID_W-1:0]                rom_obj_id,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [PIX_W-1:0]               rom_q,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PIX_W-1:0]               sprite_pixel,
  output logic [$clog2(NUM_LAYERS):0]    out_layer,
  output logic [1:0]                     dbg_state
);

  localparam int OL_W = $clog2(NUM_LAYERS) + 1;
  localparam logic [NUM_LAYERS-1:0] ONE_L = NUM_LAYERS'(1);

  state_t                         state;
  logic [NUM_LAYERS-1:0]          pend_r;
  logic [NUM_LAYERS*ID_W-1:0]     ids_r;
  logic [NUM_LAYERS*ADDR_W-1:0]   addrs_r;
  logic [OL_W-1:0]                cur_layer;

  logic [OL_W-1:0]   sel_idx;
  logic              sel_any;
  logic [ID_W-1:0]   sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic              tc_hit;
  logic [PIX_W-1:0]  tc_color;

  sprite_prio_enc #(.N(NUM_LAYERS), .IDX_W(OL_W)) u_prio_enc (
    .mask (pend_r),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  // Route the id and address of the currently selected layer.
  always_comb begin
    sel_id   = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (sel_idx == OL_W'(i)) begin
        sel_id   = ids_r[i*ID_W +: ID_W];
        sel_addr = addrs_r[i*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef SPRITE_MUX_TESTCOLOR_EN
  // Object ids 0 and 1 resolve to fixed opaque colours with no ROM cycle.
  always_comb begin
    tc_hit   = sel_any && (sel_id == ID_W'(0) || sel_id == ID_W'(1));
    tc_color = (sel_id == ID_W'(0)) ? PIX_W'(TEST_COLOR0) : PIX_W'(TEST_COLOR1);
  end
`else
  // Every object id is fetched from the ROM.
  always_comb begin
    tc_hit   = 1'b0;
    tc_color = '0;
  end
`endif

  // ROM strobe and bus are live only while a real fetch is issued from READ.
  always_comb begin
    rom_en     = (state == S_READ) && sel_any && !tc_hit;
    rom_obj_id = rom_en ? sel_id : '0;
    rom_addr   = rom_en ? sel_addr : '0;
  end

  assign in_ready  = (state == S_IDLE);
  assign dbg_state = state;

  // Resolver FSM. An empty mask still passes through READ, which finds no
  // pending bit and resolves straight to background without a ROM cycle.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pend_r       <= '0;
      ids_r        <= '0;
      addrs_r      <= '0;
      cur_layer    <= '0;
      out_valid    <= 1'b0;
      sprite_pixel <= '0;
      out_layer    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            pend_r  <= layer_hit;
            ids_r   <= layer_obj_id;
            addrs_r <= layer_addr;
            state   <= S_READ;
          end
        end
        S_READ: begin
          if (!sel_any) begin
            sprite_pixel <= PIX_W'(BG_COLOR);
            out_layer    <= OL_W'(NUM_LAYERS);
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end else if (tc_hit) begin
            sprite_pixel <= tc_color;
            out_layer    <= sel_idx;
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end else begin
            cur_layer <= sel_idx;
            pend_r    <= pend_r & (pend_r - ONE_L);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom_q != PIX_W'(TRANSP_KEY)) begin
            sprite_pixel <= rom_q;
            out_layer    <= cur_layer;
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end else if (pend_r != '0) begin
            state <= S_READ;
          end else begin
            sprite_pixel <= PIX_W'(BG_COLOR);
            out_layer    <= OL_W'(NUM_LAYERS);
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_layer_mux.sv
// Bench for sprite_layer_mux: table of pixel requests with expected colour,
// layer, latency and ROM read set, plus hand-written hold, reset and
// test-colour sequences. Compile with SPRITE_MUX_TESTCOLOR_EN to match a DUT
// built with that macro.
module tb_sprite_layer_mux;
  import sprite_pkg::*;

  localparam int NL = 4;
  localparam int AW = 10;
  localparam int IW = 5;
  localparam int PW = 24;
  localparam int OW = 3;

  logic           clk50 = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [NL-1:0]  layer_hit;
  logic [NL*IW-1:0] layer_obj_id;
  logic [NL*AW-1:0] layer_addr;
  logic           rom_en;
  logic [IW-1:0]  rom_obj_id;
  logic [AW-1:0]  rom_addr;
  logic [PW-1:0]  rom_q;
  logic           out_valid;
  logic           out_ready;
  logic [PW-1:0]  sprite_pixel;
  logic [OW-1:0]  out_layer;
  logic [1:0]     dbg_state;

  sprite_layer_mux #(.NUM_LAYERS(NL), .ADDR_W(AW), .ID_W(IW), .PIX_W(PW)) dut (
    .clk50        (clk50),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .layer_hit    (layer_hit),
    .layer_obj_id (layer_obj_id),
    .layer_addr   (layer_addr),
    .rom_en       (rom_en),
    .rom_obj_id   (rom_obj_id),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sprite_pixel (sprite_pixel),
    .out_layer    (out_layer),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #10 clk50 = ~clk50;

  // ---------------- counters and scoreboard state ----------------
  int n_vec = 0;
  int n_miscmp = 0;
  logic [PW+OW-1:0] exp_q[$];
  logic [IW-1:0]    rd_log[$];
  int               bus_err;
  logic [PW-1:0]    rom_mem [32];
  logic [AW-1:0]    addr_mem [32];
  logic [IW-1:0]    ids [NL];
  logic [PW-1:0]    rom_next;

  typedef struct packed {
    logic [3:0]       hit;
    logic [3:0][23:0] col;
    logic [23:0]      exp_pix;
    logic [2:0]       exp_lay;
    logic [7:0]       exp_lat;
    logic [3:0]       exp_rd;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ROM model: data one cycle after the strobe ----------------
  always @(negedge clk50) begin
    if (rom_en) rom_next = rom_mem[rom_obj_id];
    else        rom_next = PW'($urandom);
  end

  always @(posedge clk50) rom_q <= rom_next;

  // ROM bus monitor: log reads, check address, flag a dirty idle bus.
  always @(negedge clk50) begin
    if (!reset) begin
      if (rom_en) begin
        rd_log.push_back(rom_obj_id);
        check("rom_addr", 32'(rom_addr), 32'(addr_mem[rom_obj_id]));
      end else if (rom_obj_id != '0 || rom_addr != '0) begin
        bus_err++;
      end
    end
  end

  // Output scoreboard: pop the expected result on each output handshake.
  always @(negedge clk50) begin
    logic [PW+OW-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miscmp++;
        $display("FAIL sb_underflow: got %h with no expected entry", {sprite_pixel, out_layer});
      end else begin
        e = exp_q.pop_front();
        check("sb_pixel_layer", 32'({sprite_pixel, out_layer}), 32'(e));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic load_layers(input vec_t v, input logic [IW-1:0] id0);
    for (int i = 0; i < NL; i++) begin
      ids[i] = (i == 0) ? id0 : IW'(8 + i);
      rom_mem[ids[i]]  = v.col[i];
      addr_mem[ids[i]] = AW'(16 * i + 3);
    end
    layer_hit    = v.hit;
    layer_obj_id = {ids[3], ids[2], ids[1], ids[0]};
    layer_addr   = {addr_mem[ids[3]], addr_mem[ids[2]], addr_mem[ids[1]], addr_mem[ids[0]]};
  endtask

  // Apply one request, measure latency, hold the result for 'hold' cycles
  // (pulsing in_valid meanwhile), then complete the output handshake.
  task automatic run_vec(input vec_t v, input logic [IW-1:0] id0, input int hold);
    int lat;
    logic [3:0] rd_mask;
    logic ordered;
    @(posedge clk50); #1;
    load_layers(v, id0);
    rd_log.delete();
    bus_err = 0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    exp_q.push_back({v.exp_pix, v.exp_lay});
    @(posedge clk50); #1;
    in_valid     = 1'b0;
    layer_hit    = NL'($urandom);
    layer_obj_id = (NL*IW)'($urandom);
    layer_addr   = (NL*AW)'($urandom);
    lat = 0;
    do begin
      @(negedge clk50);
      lat++;
    end while (!out_valid && lat < 40);
    check("latency", 32'(lat), 32'(v.exp_lat));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk50); #1;
      in_valid  = c[0];
      layer_hit = NL'($urandom);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pixel", 32'({sprite_pixel, out_layer}), 32'({v.exp_pix, v.exp_lay}));
    end
    @(posedge clk50); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk50); #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    rd_mask = '0;
    ordered = 1'b1;
    for (int k = 0; k < rd_log.size(); k++) begin
      for (int l = 0; l < NL; l++)
        if (rd_log[k] == ids[l]) rd_mask[l] = 1'b1;
      if (k > 0 && rd_log[k] <= rd_log[k-1] && id0 >= IW'(8)) ordered = 1'b0;
    end
    check("rom_reads", 32'(rd_mask), 32'(v.exp_rd));
    check("rom_read_count", 32'(rd_log.size()), 32'($countones(v.exp_rd)));
    check("rom_order", 32'(ordered), 32'd1);
    check("rom_idle_bus", 32'(bus_err), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t tc;
    int n;
    // {hit, col[3..0], exp_pix, exp_lay, exp_lat, exp_rd}
    vecs[0] = {4'b0000, {24'h111111, 24'h222222, 24'h333333, 24'h444444}, 24'h000000, 3'd4, 8'd2, 4'b0000};
    vecs[1] = {4'b0001, {24'h111111, 24'h222222, 24'h333333, 24'hA1B2C3}, 24'hA1B2C3, 3'd0, 8'd3, 4'b0001};
    vecs[2] = {4'b0110, {24'h111111, 24'h123456, 24'hFF00FF, 24'h444444}, 24'h123456, 3'd2, 8'd5, 4'b0110};
    vecs[3] = {4'b1111, {24'h00FF00, 24'hFF00FF, 24'hFF00FF, 24'hFF00FF}, 24'h00FF00, 3'd3, 8'd9, 4'b1111};
    vecs[4] = {4'b1010, {24'hFF00FF, 24'h333333, 24'hFF00FF, 24'h444444}, 24'h000000, 3'd4, 8'd5, 4'b1010};
    vecs[5] = {4'b1100, {24'h777777, 24'h0000FF, 24'h222222, 24'h444444}, 24'h0000FF, 3'd2, 8'd3, 4'b0100};
    vecs[6] = {4'b0001, {24'h111111, 24'h222222, 24'h333333, 24'hFF00FF}, 24'h000000, 3'd4, 8'd3, 4'b0001};

    reset        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    layer_hit    = '0;
    layer_obj_id = '0;
    layer_addr   = '0;
    rom_q        = '0;
    bus_err      = 0;
    for (int i = 0; i < 32; i++) begin
      rom_mem[i]  = '0;
      addr_mem[i] = '0;
    end

    // Reset state
    #25;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_pixel_layer", 32'({sprite_pixel, out_layer}), 32'd0);
    @(negedge clk50);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) run_vec(vecs[i], IW'(8), $urandom_range(0, 2));

    // Back-pressure: result held for 4 cycles while in_valid pulses
    run_vec(vecs[1], IW'(8), 4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk50);
      check("idle_after_hold", 32'(dbg_state), 32'(S_IDLE));
      check("no_spurious_out", 32'(out_valid), 32'd0);
    end

    // Reset while waiting for ROM data
    @(posedge clk50); #1;
    load_layers(vecs[2], IW'(8));
    layer_hit = 4'b0010;
    in_valid  = 1'b1;
    @(posedge clk50); #1;
    in_valid = 1'b0;
    n = 0;
    while (dbg_state != 2'(S_WAIT) && n < 10) begin
      @(posedge clk50); #1;
      n++;
    end
    check("reach_wait", 32'(dbg_state), 32'(S_WAIT));
    #4 reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_rom_en", 32'(rom_en), 32'd0);
    check("midrst_pixel_layer", 32'({sprite_pixel, out_layer}), 32'd0);
    @(negedge clk50);
    reset = 1'b0;
    run_vec(vecs[1], IW'(8), 0);

    // Layer 0 with object id 1
    tc = {4'b0001, {24'h111111, 24'h222222, 24'h333333, 24'h445566}, 24'h000000, 3'd0, 8'd0, 4'b0000};
`ifdef SPRITE_MUX_TESTCOLOR_EN
    tc.exp_pix = 24'h87FF00;
    tc.exp_lat = 8'd2;
    tc.exp_rd  = 4'b0000;
`else
    tc.exp_pix = 24'h445566;
    tc.exp_lat = 8'd3;
    tc.exp_rd  = 4'b0001;
`endif
    run_vec(tc, IW'(1), 1);

    repeat (2) @(posedge clk50);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    n_miscmp++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $fatal(1, "timeout");
  end

endmodule
